// File: rtl/step_timer_bank.sv
// step_timer_bank: a bank of independent down-counter timers for microstepper
// step timing. Each channel loads a count and decrements it to zero. On the
// terminal cycle it emits a one-cycle done pulse. A channel can run one-shot
// or auto-reload, and supports hold (pause) and abort.
//
// Per-channel state table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | not armed; counter holds its value, done stays low
//   ST_RUN  | armed; counting down, or frozen while hold is asserted
//
// Priority on each edge, highest first:
//   abort > start > hold > decrement > terminal.
// On the terminal cycle the counter is already 0. The channel raises done,
// then either reloads (periodic) or returns to idle (one-shot).
module step_timer_bank #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       start_enable,
  input  logic [CHANNELS*WIDTH-1:0] start_time,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       hold,
  input  logic [CHANNELS-1:0]       abort,
  output logic [CHANNELS*WIDTH-1:0] timer,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic                      any_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state      [CHANNELS];
  state_t            w_state_nxt  [CHANNELS];
  logic [WIDTH-1:0]  r_count      [CHANNELS];
  logic [WIDTH-1:0]  w_count_nxt  [CHANNELS];
  logic [WIDTH-1:0]  r_reload     [CHANNELS];
  logic [WIDTH-1:0]  w_reload_nxt [CHANNELS];
  logic [CHANNELS-1:0] r_mode;
  logic [CHANNELS-1:0] w_mode_nxt;
  logic [CHANNELS-1:0] r_done;
  logic [CHANNELS-1:0] w_done_nxt;

  // Next-state logic for every channel; hold leaves all state untouched
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_done_nxt   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (abort[i]) begin
        w_state_nxt[i] = ST_IDLE;
        w_count_nxt[i] = '0;
      end else if (start_enable[i]) begin
        w_state_nxt[i]  = ST_RUN;
        w_count_nxt[i]  = start_time[i*WIDTH +: WIDTH];
        w_reload_nxt[i] = start_time[i*WIDTH +: WIDTH];
        w_mode_nxt[i]   = periodic[i];
      end else if (r_state[i] == ST_RUN) begin
        if (!hold[i]) begin
          if (r_count[i] != '0) begin
            w_count_nxt[i] = r_count[i] - WIDTH'(1);
          end else begin
            // Terminal cycle: the counter is already 0
            w_done_nxt[i] = 1'b1;
            if (r_mode[i]) begin
              w_count_nxt[i] = r_reload[i];
            end else begin
              w_state_nxt[i] = ST_IDLE;
            end
          end
        end
      end
    end
  end

  // Per-channel state registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= ST_IDLE;
        r_count[i]  <= '0;
        r_reload[i] <= '0;
      end
      r_mode <= '0;
      r_done <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Pack the counter registers straight onto the outputs, with no extra latency
  always_comb begin
    timer = '0;
    busy  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      timer[i*WIDTH +: WIDTH] = r_count[i];
      busy[i]                 = (r_state[i] == ST_RUN);
    end
  end

  assign done     = r_done;
  assign any_done = |r_done;

endmodule

// File: tb/tb_step_timer_bank.sv
// Testbench for step_timer_bank (WIDTH=16, CHANNELS=4).
// Expected per-cycle values are queued when stimulus is driven and checked
// one cycle later.
module tb_step_timer_bank;
  localparam int W = 16;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [C-1:0]   start_enable = '0;
  logic [C*W-1:0] start_time = '0;
  logic [C-1:0]   periodic = '0;
  logic [C-1:0]   hold = '0;
  logic [C-1:0]   abort = '0;
  logic [C*W-1:0] timer;
  logic [C-1:0]   busy;
  logic [C-1:0]   done;
  logic           any_done;

  step_timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .resetn(resetn), .start_enable(start_enable),
    .start_time(start_time), .periodic(periodic), .hold(hold),
    .abort(abort), .timer(timer), .busy(busy), .done(done),
    .any_done(any_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         ch;
    logic [W-1:0] tm;
    logic       bz;
    logic       dn;
    logic       ad;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int ch, input int tm,
                      input bit bz, input bit dn, input bit ad);
    exp_t e;
    e.nm = nm; e.ch = ch; e.tm = tm[W-1:0]; e.bz = bz; e.dn = dn; e.ad = ad;
    q.push_back(e);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_checks += 4;
    if (timer !== '0) $display("FAIL reset timer got %h want 0", timer); else n_pass++;
    if (busy !== '0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
    if (done !== '0) $display("FAIL reset done got %b want 0", done); else n_pass++;
    if (any_done !== 1'b0) $display("FAIL reset any_done got %b want 0", any_done); else n_pass++;
    cyc();
    cyc();
    resetn = 1'b1;
    // hold while idle must do nothing
    hold = '1;
    cyc();
    hold = '0;
    n_checks += 2;
    if (timer !== '0) $display("FAIL idle_hold timer got %h want 0", timer); else n_pass++;
    if (busy !== '0) $display("FAIL idle_hold busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_oneshot();
    exp_t e;
    int tm_e[8] = '{5, 4, 3, 2, 1, 0, 0, 0};
    bit bz_e[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    bit dn_e[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int s = 0; s < 8; s++) begin
      if (s == 0) begin
        start_enable[0] = 1'b1; start_time[0 +: W] = 16'd5; periodic[0] = 1'b0;
      end else begin
        start_enable[0] = 1'b0;
        periodic[0] = 1'b1;  // mode is latched on start only
      end
      push("oneshot", 0, tm_e[s], bz_e[s], dn_e[s], dn_e[s]);
      push("oneshot_ch1", 1, 0, 1'b0, 1'b0, dn_e[s]);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s timer%0d got %0d want %0d", e.nm, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s busy%0d got %b want %b", e.nm, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s done%0d got %b want %b", e.nm, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s any_done got %b want %b", e.nm, any_done, e.ad); else n_pass++;
      end
    end
    periodic[0] = 1'b0;
  endtask

  task automatic test_periodic();
    exp_t e;
    bit dn;
    for (int s = 0; s < 25; s++) begin
      start_enable[1] = (s == 0);
      if (s == 0) begin
        start_time[1*W +: W] = 16'd3; periodic[1] = 1'b1;
      end
      abort[1] = (s == 24);
      dn = (s >= 4) && (s % 4 == 0) && (s != 24);
      if (s == 24) push("periodic_abort", 1, 0, 1'b0, 1'b0, 1'b0);
      else push("periodic", 1, 3 - (s % 4), 1'b1, dn, dn);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s timer%0d got %0d want %0d", e.nm, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s busy%0d got %b want %b", e.nm, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s done%0d got %b want %b", e.nm, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s any_done got %b want %b", e.nm, any_done, e.ad); else n_pass++;
      end
    end
    abort[1] = 1'b0; periodic[1] = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    int tm_a[10] = '{4, 3, 2, 2, 2, 2, 1, 0, 0, 0};
    bit bz_a[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit dn_a[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int tm_b[6]  = '{1, 0, 0, 0, 0, 0};
    bit bz_b[6]  = '{1, 1, 1, 1, 0, 0};
    bit dn_b[6]  = '{0, 0, 0, 0, 1, 0};
    // hold mid-count at counter==2
    for (int s = 0; s < 10; s++) begin
      start_enable[0] = (s == 0);
      start_time[0 +: W] = 16'd4;
      hold[0] = (s >= 3 && s <= 5);
      push("hold_mid", 0, tm_a[s], bz_a[s], dn_a[s], dn_a[s]);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s timer%0d got %0d want %0d", e.nm, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s busy%0d got %b want %b", e.nm, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s done%0d got %b want %b", e.nm, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s any_done got %b want %b", e.nm, any_done, e.ad); else n_pass++;
      end
    end
    // hold at the terminal cycle delays done until release
    for (int s = 0; s < 6; s++) begin
      start_enable[0] = (s == 0);
      start_time[0 +: W] = 16'd1;
      hold[0] = (s == 2 || s == 3);
      push("hold_term", 0, tm_b[s], bz_b[s], dn_b[s], dn_b[s]);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s timer%0d got %0d want %0d", e.nm, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s busy%0d got %b want %b", e.nm, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s done%0d got %b want %b", e.nm, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s any_done got %b want %b", e.nm, any_done, e.ad); else n_pass++;
      end
    end
    hold[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // restart at counter==3, abort+start, start on terminal, N=0 one-shot,
    // periodic reload 0, abort on terminal
    int  tm_e[29] = '{6,5,4,3,2,1,0,0,0,  5,4,0,0,0,  2,1,0,1,0,0,0,  0,0,0,  0,0,0,0,0};
    bit  bz_e[29] = '{1,1,1,1,1,1,1,0,0,  1,1,0,0,0,  1,1,1,1,1,0,0,  1,0,0,  1,1,1,0,0};
    bit  dn_e[29] = '{0,0,0,0,0,0,0,1,0,  0,0,0,0,0,  0,0,0,0,0,1,0,  0,1,0,  0,1,1,0,0};
    int  sv_e[29] = '{6,0,0,0,2,0,0,0,0,  5,0,7,0,0,  2,0,0,1,0,0,0,  0,0,0,  0,0,0,0,0};
    bit  st_e[29] = '{1,0,0,0,1,0,0,0,0,  1,0,1,0,0,  1,0,0,1,0,0,0,  1,0,0,  1,0,0,0,0};
    bit  ab_e[29] = '{0,0,0,0,0,0,0,0,0,  0,0,1,0,0,  0,0,0,0,0,0,0,  0,0,0,  0,0,0,1,0};
    for (int s = 0; s < 29; s++) begin
      start_enable[0] = st_e[s];
      start_time[0 +: W] = sv_e[s][W-1:0];
      periodic[0] = (s == 24);
      abort[0] = ab_e[s];
      push("back_to_back", 0, tm_e[s], bz_e[s], dn_e[s], dn_e[s]);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s step%0d timer%0d got %0d want %0d", e.nm, s, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s step%0d busy%0d got %b want %b", e.nm, s, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s step%0d done%0d got %b want %b", e.nm, s, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s step%0d any_done got %b want %b", e.nm, s, any_done, e.ad); else n_pass++;
      end
    end
    abort[0] = 1'b0; periodic[0] = 1'b0; start_enable[0] = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    start_enable[1:0] = 2'b11;
    start_time[0 +: W] = 16'd20;
    start_time[W +: W] = 16'd30;
    periodic[1] = 1'b1;
    cyc();
    start_enable = '0;
    periodic = '0;
    cyc();
    cyc();
    n_checks += 1;
    if (busy[1:0] !== 2'b11) $display("FAIL async_pre busy got %b want 11", busy[1:0]); else n_pass++;
    #3 resetn = 1'b0;
    #1;
    n_checks += 3;
    if (timer !== '0) $display("FAIL async_reset timer got %h want 0", timer); else n_pass++;
    if (busy !== '0) $display("FAIL async_reset busy got %b want 0", busy); else n_pass++;
    if (done !== '0) $display("FAIL async_reset done got %b want 0", done); else n_pass++;
    cyc();
    resetn = 1'b1;
    for (int s = 0; s < 35; s++) begin
      push("after_reset", 0, 0, 1'b0, 1'b0, 1'b0);
      push("after_reset", 1, 0, 1'b0, 1'b0, 1'b0);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s timer%0d got %0d want %0d", e.nm, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s busy%0d got %b want %b", e.nm, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s done%0d got %b want %b", e.nm, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s any_done got %b want %b", e.nm, any_done, e.ad); else n_pass++;
      end
    end
  endtask

  task automatic test_max_value();
    exp_t e;
    bit d2, d3;
    int t3;
    for (int s = 0; s <= 65538; s++) begin
      start_enable[3] = (s == 0);
      start_enable[2] = (s == 0);
      if (s == 0) begin
        start_time[3*W +: W] = 16'hFFFF;
        start_time[2*W +: W] = 16'd100;
        periodic[2] = 1'b1;
      end
      abort[2] = (s == 65538);
      if (s <= 65535) begin t3 = 65535 - s; d3 = 1'b0; end
      else begin t3 = 0; d3 = (s == 65536); end
      if (s == 65538) begin
        d2 = 1'b0;
        push("max_ch2_abort", 2, 0, 1'b0, 1'b0, d3);
      end else begin
        d2 = (s > 0) && (s % 101 == 0);
        push("max_ch2", 2, 100 - (s % 101), 1'b1, d2, d2 | d3);
      end
      push("max_ch3", 3, t3, (s <= 65535), d3, d2 | d3);
      cyc();
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks += 4;
        if (timer[e.ch*W +: W] !== e.tm) $display("FAIL %s step%0d timer%0d got %0d want %0d", e.nm, s, e.ch, timer[e.ch*W +: W], e.tm); else n_pass++;
        if (busy[e.ch] !== e.bz) $display("FAIL %s step%0d busy%0d got %b want %b", e.nm, s, e.ch, busy[e.ch], e.bz); else n_pass++;
        if (done[e.ch] !== e.dn) $display("FAIL %s step%0d done%0d got %b want %b", e.nm, s, e.ch, done[e.ch], e.dn); else n_pass++;
        if (any_done !== e.ad) $display("FAIL %s step%0d any_done got %b want %b", e.nm, s, any_done, e.ad); else n_pass++;
      end
    end
    abort = '0; periodic = '0; start_enable = '0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_max_value();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
